// File: rtl/pll_rst_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pll_rst_sequencer
// Purpose  : PLL reset driver, lock qualifier and staged multi-domain reset
//            release. Define PLL_RST_SEQ_TIMEOUT_EN for WAIT_LOCK timeout/retry.
// Revision : 1.0 - initial release
// ============================================================================
module pll_rst_sequencer #(
    parameter int NUM_DOMAINS      = 4,
    parameter int PLL_RST_CYC      = 64,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int STAGE_GAP_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int CNT_W            = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pll_lock_i,
    input  logic                   clr_cnt_i,
    output logic                   pll_reset_o,
    output logic [NUM_DOMAINS-1:0] rst_o,
    output logic                   all_ready_o,
    output logic [CNT_W-1:0]       lock_loss_cnt_o,
    output logic                   timeout_o
);

    localparam int c_RST_W   = $clog2(PLL_RST_CYC + 1);
    localparam int c_STB_W   = $clog2(LOCK_STABLE_CYC + 1);
    localparam int c_REL_MAX = (NUM_DOMAINS - 1) * STAGE_GAP_CYC;
    localparam int c_REL_W   = $clog2(c_REL_MAX + 2);

    localparam logic [c_RST_W-1:0] c_RST_LAST = c_RST_W'(PLL_RST_CYC - 1);
    localparam logic [c_STB_W-1:0] c_STB_LAST = c_STB_W'(LOCK_STABLE_CYC - 1);
    localparam logic [c_REL_W-1:0] c_REL_LAST = c_REL_W'(c_REL_MAX);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    generate
        if (NUM_DOMAINS < 1 || PLL_RST_CYC < 1 || LOCK_STABLE_CYC < 1 ||
            STAGE_GAP_CYC < 1 || LOCK_TIMEOUT_CYC < 1 || CNT_W < 1) begin : g_param_check
            $error("pll_rst_sequencer: illegal parameter value");
        end
    endgenerate

    state_t                 r_state, w_state_nxt;
    logic                   r_lock_m, r_lock_s;
    logic [c_RST_W-1:0]     r_rst_cnt, w_rst_cnt_nxt;
    logic [c_STB_W-1:0]     r_stb_cnt, w_stb_cnt_nxt;
    logic [c_REL_W-1:0]     r_rel_cnt, w_rel_cnt_nxt, w_rel_inc;
    logic                   w_pll_reset_nxt;
    logic [NUM_DOMAINS-1:0] w_rst_nxt;
    logic                   w_ready_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_loss;
    logic                   w_to_expire;

    // Lock comes from the PLL's own clock domain; two-flop synchroniser.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_m <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_lock_m <= pll_lock_i;
            r_lock_s <= r_lock_m;
        end
    end

    assign w_rel_inc = r_rel_cnt + c_REL_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_rst_cnt_nxt   = r_rst_cnt;
        w_stb_cnt_nxt   = r_stb_cnt;
        w_rel_cnt_nxt   = r_rel_cnt;
        w_pll_reset_nxt = pll_reset_o;
        w_rst_nxt       = rst_o;
        w_ready_nxt     = 1'b0;
        w_loss          = 1'b0;
        w_cnt_nxt       = lock_loss_cnt_o;

        case (r_state)
            ST_PLL_RST: begin
                w_pll_reset_nxt = 1'b1;
                w_rst_nxt       = '1;
                if (r_rst_cnt == c_RST_LAST) begin
                    w_state_nxt     = ST_WAIT_LOCK;
                    w_pll_reset_nxt = 1'b0;
                    w_stb_cnt_nxt   = '0;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + c_RST_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // Stability completing on the timeout cycle takes priority.
                if (r_lock_s && (r_stb_cnt == c_STB_LAST)) begin
                    w_state_nxt   = ST_RELEASE;
                    w_rst_nxt[0]  = 1'b0;
                    w_rel_cnt_nxt = '0;
                end else if (w_to_expire) begin
                    w_state_nxt     = ST_PLL_RST;
                    w_pll_reset_nxt = 1'b1;
                    w_rst_cnt_nxt   = '0;
                end else if (r_lock_s) begin
                    w_stb_cnt_nxt = r_stb_cnt + c_STB_W'(1);
                end else begin
                    w_stb_cnt_nxt = '0;
                end
            end
            ST_RELEASE: begin
                if (!r_lock_s) begin
                    w_loss = 1'b1;
                end else if (r_rel_cnt == c_REL_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_rel_cnt_nxt = w_rel_inc;
                    for (int k = 1; k < NUM_DOMAINS; k++) begin
                        if (w_rel_inc == c_REL_W'(k * STAGE_GAP_CYC)) begin
                            w_rst_nxt[k] = 1'b0;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (!r_lock_s) begin
                    w_loss = 1'b1;
                end else begin
                    w_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_PLL_RST;
            end
        endcase

        if (w_loss) begin
            w_state_nxt     = ST_PLL_RST;
            w_pll_reset_nxt = 1'b1;
            w_rst_nxt       = '1;
            w_rst_cnt_nxt   = '0;
            w_ready_nxt     = 1'b0;
        end

        if (clr_cnt_i) begin
            w_cnt_nxt = w_loss ? CNT_W'(1) : '0;
        end else if (w_loss && (lock_loss_cnt_o != c_CNT_MAX)) begin
            w_cnt_nxt = lock_loss_cnt_o + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_PLL_RST;
            r_rst_cnt       <= '0;
            r_stb_cnt       <= '0;
            r_rel_cnt       <= '0;
            pll_reset_o     <= 1'b1;
            rst_o           <= '1;
            all_ready_o     <= 1'b0;
            lock_loss_cnt_o <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_rst_cnt       <= w_rst_cnt_nxt;
            r_stb_cnt       <= w_stb_cnt_nxt;
            r_rel_cnt       <= w_rel_cnt_nxt;
            pll_reset_o     <= w_pll_reset_nxt;
            rst_o           <= w_rst_nxt;
            all_ready_o     <= w_ready_nxt;
            lock_loss_cnt_o <= w_cnt_nxt;
        end
    end

`ifdef PLL_RST_SEQ_TIMEOUT_EN
    localparam int                c_TO_W    = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(LOCK_TIMEOUT_CYC - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_timeout;

    assign w_to_expire = (r_state == ST_WAIT_LOCK) && (r_to_cnt == c_TO_LAST);
    assign timeout_o   = r_timeout;

    // Timer restarts on every WAIT_LOCK entry; the only WAIT_LOCK->PLL_RST exit is a timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt  <= ((r_state == ST_WAIT_LOCK) && (w_state_nxt == ST_WAIT_LOCK)) ?
                         r_to_cnt + c_TO_W'(1) : '0;
            r_timeout <= r_timeout | (w_to_expire && (w_state_nxt == ST_PLL_RST));
        end
    end
`else
    assign w_to_expire = 1'b0;
    assign timeout_o   = 1'b0;
`endif

endmodule

`default_nettype wire
